// File: rtl/oram_access_ctrl.sv
// Single-access ORAM sequencer: remaps a block's leaf in the position map, scans the
// root-to-leaf path for the block, removes it, and reinserts it as a fresh root tuple.
module oram_access_ctrl #(
    parameter int A = 8,
    parameter int D = 6,
    parameter int K = 3,
    localparam int TW = 8*A + 2*D + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [D-1:0]      req_block,
    input  logic [8*A-1:0]    req_data,
    input  logic [D-2:0]      rnd_leaf,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [8*A-1:0]    resp_data,
    output logic              resp_hit,
    output logic              overflow,
    output logic [D-1:0]      pm_addr,
    output logic              pm_rd_en,
    input  logic [D-1:0]      pm_rdata,
    output logic              pm_wr_en,
    output logic [D-1:0]      pm_wdata,
    output logic [D-1:0]      tr_addr,
    output logic              tr_rd_en,
    input  logic [K*TW-1:0]   tr_rdata,
    output logic              tr_wr_en,
    output logic [K*TW-1:0]   tr_wdata
);

    localparam int VW      = 8*A;
    localparam int VAL_LSB = 2;
    localparam int BN_LSB  = 2 + VW;
    localparam int PV_BIT  = 2 + VW + D;
    localparam int POS_LSB = 3 + VW + D;
    localparam int LW      = $clog2(D);
    localparam int IW      = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_POS_RD, S_POS_WAIT, S_PATH_RD, S_PATH_CMP,
        S_PATH_WR, S_ROOT_RD, S_ROOT_INS, S_RESP
    } state_t;

    state_t state, state_nx;

    logic            wr_q;
    logic [D-1:0]    block_q;
    logic [VW-1:0]   data_q;
    logic [D-2:0]    old_leaf;
    logic [D-2:0]    new_leaf;
    logic [LW-1:0]   level;
    logic [D-1:0]    node;
    logic            hit;
    logic [VW-1:0]   found_val;
    logic            found_vv;
    logic [K*TW-1:0] bucket_q;

    logic            match_any;
    logic [IW-1:0]   match_idx;
    logic            empty_any;
    logic [IW-1:0]   empty_idx;
    logic [K*TW-1:0] cleared_bucket;
    logic [TW-1:0]   new_tuple;
    logic [K*TW-1:0] ins_bucket;

    // Descending scan so the lowest matching / empty slot wins.
    always_comb begin : slot_scan
        match_any = 1'b0;
        match_idx = '0;
        empty_any = 1'b0;
        empty_idx = '0;
        for (int k = K-1; k >= 0; k--) begin
            if (tr_rdata[k*TW] && tr_rdata[k*TW + PV_BIT] &&
                tr_rdata[k*TW + POS_LSB +: D-1] == old_leaf &&
                tr_rdata[k*TW + BN_LSB +: D] == block_q) begin
                match_any = 1'b1;
                match_idx = IW'(k);
            end
            if (!tr_rdata[k*TW]) begin
                empty_any = 1'b1;
                empty_idx = IW'(k);
            end
        end
    end

    always_comb begin : tuple_build
        cleared_bucket = tr_rdata;
        cleared_bucket[int'(match_idx)*TW] = 1'b0;

        new_tuple                      = '0;
        new_tuple[0]                   = 1'b1;
        new_tuple[1]                   = wr_q | found_vv;
        new_tuple[VAL_LSB +: VW]       = wr_q ? data_q : found_val;
        new_tuple[BN_LSB +: D]         = block_q;
        new_tuple[PV_BIT]              = 1'b1;
        new_tuple[POS_LSB +: D-1]      = new_leaf;

        ins_bucket = tr_rdata;
        ins_bucket[int'(empty_idx)*TW +: TW] = new_tuple;
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin : fsm_next
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_hit   = 1'b0;
        overflow   = 1'b0;
        pm_addr    = '0;
        pm_rd_en   = 1'b0;
        pm_wr_en   = 1'b0;
        pm_wdata   = '0;
        tr_addr    = '0;
        tr_rd_en   = 1'b0;
        tr_wr_en   = 1'b0;
        tr_wdata   = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = S_POS_RD;
            end
            S_POS_RD: begin
                pm_rd_en = 1'b1;
                pm_addr  = block_q;
                state_nx = S_POS_WAIT;
            end
            S_POS_WAIT: begin
                pm_wr_en = 1'b1;
                pm_addr  = block_q;
                pm_wdata = {1'b1, rnd_leaf};
                state_nx = pm_rdata[D-1] ? S_PATH_RD : S_ROOT_RD;
            end
            S_PATH_RD: begin
                tr_rd_en = 1'b1;
                tr_addr  = node - D'(1);
                state_nx = S_PATH_CMP;
            end
            S_PATH_CMP: begin
                if (match_any)                 state_nx = S_PATH_WR;
                else if (level == LW'(D-1))    state_nx = S_ROOT_RD;
                else                           state_nx = S_PATH_RD;
            end
            S_PATH_WR: begin
                tr_wr_en = 1'b1;
                tr_addr  = node - D'(1);
                tr_wdata = bucket_q;
                state_nx = S_ROOT_RD;
            end
            S_ROOT_RD: begin
                tr_rd_en = 1'b1;
                state_nx = S_ROOT_INS;
            end
            S_ROOT_INS: begin
                if (empty_any) begin
                    tr_wr_en = 1'b1;
                    tr_wdata = ins_bucket;
                end else begin
                    overflow = 1'b1;
                end
                state_nx = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit;
                resp_data  = (hit && !wr_q) ? found_val : '0;
                if (resp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // NOTE: the bucket copy is cleared on reset too; it is a register, not a RAM, so this is cheap and keeps outputs deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            block_q   <= '0;
            data_q    <= '0;
            old_leaf  <= '0;
            new_leaf  <= '0;
            level     <= '0;
            node      <= '0;
            hit       <= 1'b0;
            found_val <= '0;
            found_vv  <= 1'b0;
            bucket_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        block_q   <= req_block;
                        data_q    <= req_data;
                        hit       <= 1'b0;
                        found_val <= '0;
                        found_vv  <= 1'b0;
                    end
                end
                S_POS_WAIT: begin
                    old_leaf <= pm_rdata[D-2:0];
                    new_leaf <= rnd_leaf;
                    level    <= '0;
                    node     <= D'(1);
                end
                S_PATH_CMP: begin
                    if (match_any) begin
                        hit       <= 1'b1;
                        found_val <= tr_rdata[int'(match_idx)*TW + VAL_LSB +: VW];
                        found_vv  <= tr_rdata[int'(match_idx)*TW + 1];
                        bucket_q  <= cleared_bucket;
                    end else begin
                        // Leaf bit for this level selects the child: LSB steers the root.
                        level <= level + LW'(1);
                        node  <= {node[D-2:0], old_leaf[level]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oram_access_ctrl.sv
// Directed bench for oram_access_ctrl with behavioural position-map and bucket RAMs.
module tb_oram_access_ctrl;

    localparam int A  = 8;
    localparam int D  = 6;
    localparam int K  = 3;
    localparam int TW = 8*A + 2*D + 2;
    localparam int BW = K*TW;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [D-1:0]    req_block;
    logic [8*A-1:0]  req_data;
    logic [D-2:0]    rnd_leaf;
    logic            resp_valid;
    logic            resp_ready;
    logic [8*A-1:0]  resp_data;
    logic            resp_hit;
    logic            overflow;
    logic [D-1:0]    pm_addr;
    logic            pm_rd_en;
    logic [D-1:0]    pm_rdata;
    logic            pm_wr_en;
    logic [D-1:0]    pm_wdata;
    logic [D-1:0]    tr_addr;
    logic            tr_rd_en;
    logic [BW-1:0]   tr_rdata;
    logic            tr_wr_en;
    logic [BW-1:0]   tr_wdata;

    oram_access_ctrl #(.A(A), .D(D), .K(K)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_block(req_block), .req_data(req_data), .rnd_leaf(rnd_leaf),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_hit(resp_hit), .overflow(overflow),
        .pm_addr(pm_addr), .pm_rd_en(pm_rd_en), .pm_rdata(pm_rdata),
        .pm_wr_en(pm_wr_en), .pm_wdata(pm_wdata),
        .tr_addr(tr_addr), .tr_rd_en(tr_rd_en), .tr_rdata(tr_rdata),
        .tr_wr_en(tr_wr_en), .tr_wdata(tr_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models with one-cycle read latency, plus bench-side preload and strobe counters.
    logic [D-1:0]  pm_mem [0:63];
    logic [BW-1:0] tr_mem [0:63];
    logic          mem_clr  = 1'b0;
    logic          pk_pm_en = 1'b0;
    logic          pk_tr_en = 1'b0;
    logic [5:0]    pk_addr  = '0;
    logic [D-1:0]  pk_pm    = '0;
    logic [BW-1:0] pk_tr    = '0;
    int cnt_trd = 0, cnt_twr = 0, cnt_ovf = 0, cnt_both = 0, cnt_ovf_wr = 0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) begin
                pm_mem[i] <= '0;
                tr_mem[i] <= '0;
            end
        end else begin
            if (pm_rd_en) pm_rdata <= pm_mem[pm_addr];
            if (pm_wr_en) pm_mem[pm_addr] <= pm_wdata;
            if (tr_rd_en) tr_rdata <= tr_mem[tr_addr];
            if (tr_wr_en) tr_mem[tr_addr] <= tr_wdata;
            if (pk_pm_en) pm_mem[pk_addr] <= pk_pm;
            if (pk_tr_en) tr_mem[pk_addr] <= pk_tr;
        end
        if (tr_rd_en)             cnt_trd    <= cnt_trd + 1;
        if (tr_wr_en)             cnt_twr    <= cnt_twr + 1;
        if (overflow)             cnt_ovf    <= cnt_ovf + 1;
        if (tr_rd_en && tr_wr_en) cnt_both   <= cnt_both + 1;
        if (overflow && tr_wr_en) cnt_ovf_wr <= cnt_ovf_wr + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk_tuple(input logic vv, input logic [63:0] val,
                                               input logic [5:0] bn, input logic [4:0] pos);
        return {pos, 1'b1, bn, val, vv, 1'b1};
    endfunction

    function automatic logic [BW-1:0] place(input int idx, input logic [TW-1:0] t);
        logic [BW-1:0] b;
        b = '0;
        b[idx*TW +: TW] = t;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
    endtask

    task automatic poke_pm(input logic [5:0] addr, input logic [D-1:0] val);
        pk_addr = addr; pk_pm = val; pk_pm_en = 1'b1;
        tick();
        pk_pm_en = 1'b0;
    endtask

    task automatic poke_tr(input logic [5:0] addr, input logic [BW-1:0] val);
        pk_addr = addr; pk_tr = val; pk_tr_en = 1'b1;
        tick();
        pk_tr_en = 1'b0;
    endtask

    task automatic run_access(input logic wr, input logic [5:0] blk, input logic [63:0] dat,
                              input logic [4:0] leaf, input int hold,
                              output int lat, output logic [63:0] rd, output logic rh);
        req_write = wr; req_block = blk; req_data = dat; rnd_leaf = leaf;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        if (lat >= 200) check("resp_timeout", resp_valid, 1);
        rd = resp_data;
        rh = resp_hit;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", resp_valid, 1);
            check("hold_data", resp_data, rd);
            check("hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    typedef struct {
        bit            clr;
        bit            pm_pre;
        logic [5:0]    pm_blk;
        logic [D-1:0]  pm_val;
        bit            tr_pre;
        logic [5:0]    tr_addr;
        logic [BW-1:0] tr_bucket;
        logic          wr;
        logic [5:0]    blk;
        logic [63:0]   dat;
        logic [4:0]    leaf;
        int            lat;
        logic          hit;
        logic [63:0]   rdata;
        int            rds;
        int            wrs;
        logic [D-1:0]  pm_exp;
        int            root_idx;
        logic          root_vv;
        logic [63:0]   root_val;
        bit            path_chk;
        logic [5:0]    path_addr;
        logic [BW-1:0] path_exp;
    } vec_t;

    vec_t vecs [4];

    initial begin : timeout
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [63:0] rd;
        logic rh;
        int s_rd, s_wr, s_ovf;
        logic [TW-1:0] t;
        logic [BW-1:0] b;
        int seen;
        localparam logic [63:0] DX = 64'h1122334455667788;
        localparam logic [63:0] DL = 64'hA5A50000_5A5AFFFF;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_block = '0;
        req_data = '0; rnd_leaf = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_strobes", {resp_valid, resp_hit, overflow, pm_rd_en, pm_wr_en, tr_rd_en, tr_wr_en}, 0);
        check("rst_data", {resp_data, pm_addr, pm_wdata, tr_addr, tr_wdata}, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_req_ready", req_ready, 1);

        // Leaf 21 bit path, LSB first: 1 -> 3 -> 6 -> 13 -> 26 -> 53 (addr 52).
        t = mk_tuple(1'b1, DL, 6'd7, 5'd21);
        b = place(1, t);
        t[0] = 1'b0;

        vecs[0] = '{clr:1, pm_pre:0, pm_blk:0, pm_val:0, tr_pre:0, tr_addr:0, tr_bucket:'0,
                    wr:1, blk:5, dat:DX, leaf:9, lat:4, hit:0, rdata:0, rds:1, wrs:1,
                    pm_exp:6'b101001, root_idx:0, root_vv:1, root_val:DX,
                    path_chk:0, path_addr:0, path_exp:'0};
        vecs[1] = '{clr:0, pm_pre:0, pm_blk:0, pm_val:0, tr_pre:0, tr_addr:0, tr_bucket:'0,
                    wr:0, blk:5, dat:0, leaf:3, lat:7, hit:1, rdata:DX, rds:2, wrs:2,
                    pm_exp:6'b100011, root_idx:0, root_vv:1, root_val:DX,
                    path_chk:0, path_addr:0, path_exp:'0};
        vecs[2] = '{clr:1, pm_pre:1, pm_blk:7, pm_val:6'b110101, tr_pre:1, tr_addr:52, tr_bucket:b,
                    wr:0, blk:7, dat:0, leaf:12, lat:17, hit:1, rdata:DL, rds:7, wrs:2,
                    pm_exp:6'b101100, root_idx:0, root_vv:1, root_val:DL,
                    path_chk:1, path_addr:52, path_exp:place(1, t)};
        vecs[3] = '{clr:1, pm_pre:1, pm_blk:9, pm_val:6'b100100, tr_pre:0, tr_addr:0, tr_bucket:'0,
                    wr:0, blk:9, dat:0, leaf:30, lat:16, hit:0, rdata:0, rds:7, wrs:1,
                    pm_exp:6'b111110, root_idx:0, root_vv:0, root_val:0,
                    path_chk:0, path_addr:0, path_exp:'0};

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].clr)    clear_mem();
            if (vecs[i].pm_pre) poke_pm(vecs[i].pm_blk, vecs[i].pm_val);
            if (vecs[i].tr_pre) poke_tr(vecs[i].tr_addr, vecs[i].tr_bucket);
            s_rd = cnt_trd; s_wr = cnt_twr; s_ovf = cnt_ovf;
            run_access(vecs[i].wr, vecs[i].blk, vecs[i].dat, vecs[i].leaf, 0, lat, rd, rh);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_hit", i), rh, vecs[i].hit);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_tree_reads", i), cnt_trd - s_rd, vecs[i].rds);
            check($sformatf("v%0d_tree_writes", i), cnt_twr - s_wr, vecs[i].wrs);
            check($sformatf("v%0d_overflow", i), cnt_ovf - s_ovf, 0);
            check($sformatf("v%0d_pm", i), pm_mem[vecs[i].blk], vecs[i].pm_exp);
            check($sformatf("v%0d_root", i), tr_mem[0],
                  place(vecs[i].root_idx, mk_tuple(vecs[i].root_vv, vecs[i].root_val,
                                                    vecs[i].blk, vecs[i].leaf)));
            if (vecs[i].path_chk)
                check($sformatf("v%0d_path_bucket", i), tr_mem[vecs[i].path_addr], vecs[i].path_exp);
        end

        // Duplicate matches in the root: only slot 0 is removed and reused.
        clear_mem();
        poke_pm(6'd3, 6'b100110);
        poke_tr(6'd0, place(0, mk_tuple(1'b1, 64'hAAAA, 6'd3, 5'd6)) |
                      place(1, mk_tuple(1'b1, 64'hBBBB, 6'd3, 5'd6)));
        run_access(1'b0, 6'd3, 64'd0, 5'd1, 0, lat, rd, rh);
        check("dup_latency", lat, 7);
        check("dup_rdata", rd, 64'hAAAA);
        check("dup_root", tr_mem[0], place(0, mk_tuple(1'b1, 64'hAAAA, 6'd3, 5'd1)) |
                                     place(1, mk_tuple(1'b1, 64'hBBBB, 6'd3, 5'd6)));

        // Root full: tuple dropped with a single overflow pulse, response still issued.
        clear_mem();
        b = place(0, mk_tuple(1'b1, 64'd1, 6'd30, 5'd0)) |
            place(1, mk_tuple(1'b1, 64'd2, 6'd31, 5'd0)) |
            place(2, mk_tuple(1'b1, 64'd3, 6'd32, 5'd0));
        poke_tr(6'd0, b);
        s_wr = cnt_twr; s_ovf = cnt_ovf;
        run_access(1'b1, 6'd20, 64'hDEAD, 5'd2, 0, lat, rd, rh);
        check("ovf_latency", lat, 4);
        check("ovf_hit", rh, 0);
        check("ovf_pulses", cnt_ovf - s_ovf, 1);
        check("ovf_tree_writes", cnt_twr - s_wr, 0);
        check("ovf_root_kept", tr_mem[0], b);
        check("ovf_pm", pm_mem[20], 6'b100010);

        // Back-pressure on a read hit, then reset during the next access's path read.
        clear_mem();
        run_access(1'b1, 6'd5, DX, 5'd9, 0, lat, rd, rh);
        run_access(1'b0, 6'd5, 64'd0, 5'd3, 5, lat, rd, rh);
        check("bp_latency", lat, 7);
        check("bp_rdata", rd, DX);
        check("bp_hit", rh, 1);
        req_write = 1'b0; req_block = 6'd5; rnd_leaf = 5'd7; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        seen = 0;
        while (tr_rd_en !== 1'b1 && seen < 20) begin
            tick();
            seen++;
        end
        check("abort_reached_path_rd", tr_rd_en, 1);
        rst_n = 1'b0;
        #1;
        check("abort_strobes", {resp_valid, overflow, pm_rd_en, pm_wr_en, tr_rd_en, tr_wr_en}, 0);
        check("abort_req_ready", req_ready, 1);
        tick();
        rst_n = 1'b1;
        #1;
        check("abort_post_strobes", {resp_valid, overflow, pm_rd_en, pm_wr_en, tr_rd_en, tr_wr_en}, 0);
        check("abort_post_ready", req_ready, 1);
        check("abort_pm_kept", pm_mem[5], 6'b100111);
        check("abort_root_kept", tr_mem[0], place(0, mk_tuple(1'b1, DX, 6'd5, 5'd3)));
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid === 1'b1) seen++;
        end
        check("abort_no_resp", seen, 0);

        check("tree_rd_wr_overlap", cnt_both, 0);
        check("overflow_with_write", cnt_ovf_wr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
